// File: rtl/execute_stage.sv
// ============================================================================
// Module   : execute_stage
// Purpose  : RV64I execute stage - 64-bit ALU, CSR update and memory latches.
// Revision : 1.0
// ============================================================================
`default_nettype none

module execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exe_V,
    input  logic        mem_stall,
    input  logic [31:0] exe_IR,
    input  logic [63:0] exe_PC,
    input  logic [63:0] exe_ALU1,
    input  logic [63:0] exe_ALU2,
    input  logic [63:0] exe_RFD,
    input  logic [63:0] exe_CSRFD,
    output logic        mem_V,
    output logic [63:0] mem_PC,
    output logic [31:0] mem_IR,
    output logic [63:0] mem_ALU_RESULT,
    output logic [63:0] mem_SR1,
    output logic [63:0] mem_SR2,
    output logic [63:0] mem_RFD,
    output logic [63:0] mem_CSRFD
);

    localparam logic [6:0] c_opc_op      = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm  = 7'b0010011;
    localparam logic [6:0] c_opc_op32    = 7'b0111011;
    localparam logic [6:0] c_opc_op_imm32= 7'b0011011;
    localparam logic [6:0] c_opc_lui     = 7'b0110111;
    localparam logic [6:0] c_opc_jal     = 7'b1101111;
    localparam logic [6:0] c_opc_jalr    = 7'b1100111;
    localparam logic [6:0] c_opc_system  = 7'b1110011;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic        w_alt;
    logic        w_sub;
    logic [31:0] w_a32;
    logic [31:0] w_b32;
    logic [63:0] w_sra64;
    logic [31:0] w_sra32;
    logic [63:0] w_alu64;
    logic [31:0] w_alu32;
    logic [63:0] w_result;

    assign w_opcode = exe_IR[6:0];
    assign w_f3     = exe_IR[14:12];
    assign w_alt    = exe_IR[30];
    // Immediate forms never subtract: bit 30 there is part of the immediate.
    assign w_sub    = w_alt && ((w_opcode == c_opc_op) || (w_opcode == c_opc_op32));
    assign w_a32    = exe_ALU1[31:0];
    assign w_b32    = exe_ALU2[31:0];

    // Arithmetic shifts kept in their own signed expressions so the mux below
    // cannot turn them into logical shifts.
    assign w_sra64  = $signed(exe_ALU1) >>> exe_ALU2[5:0];
    assign w_sra32  = $signed(w_a32) >>> w_b32[4:0];

    always_comb begin
        w_alu64 = 64'd0;
        case (w_f3)
            3'b000: w_alu64 = w_sub ? (exe_ALU1 - exe_ALU2) : (exe_ALU1 + exe_ALU2);
            3'b001: w_alu64 = exe_ALU1 << exe_ALU2[5:0];
            3'b010: w_alu64 = {63'd0, $signed(exe_ALU1) < $signed(exe_ALU2)};
            3'b011: w_alu64 = {63'd0, exe_ALU1 < exe_ALU2};
            3'b100: w_alu64 = exe_ALU1 ^ exe_ALU2;
            3'b101: w_alu64 = w_alt ? w_sra64 : (exe_ALU1 >> exe_ALU2[5:0]);
            3'b110: w_alu64 = exe_ALU1 | exe_ALU2;
            default: w_alu64 = exe_ALU1 & exe_ALU2;
        endcase
    end

    always_comb begin
        w_alu32 = 32'd0;
        case (w_f3)
            3'b000: w_alu32 = w_sub ? (w_a32 - w_b32) : (w_a32 + w_b32);
            3'b001: w_alu32 = w_a32 << w_b32[4:0];
            3'b101: w_alu32 = w_alt ? w_sra32 : (w_a32 >> w_b32[4:0]);
            default: w_alu32 = 32'd0;
        endcase
    end

    always_comb begin
        w_result = exe_ALU1 + exe_ALU2;
        case (w_opcode)
            c_opc_op, c_opc_op_imm:     w_result = w_alu64;
            c_opc_op32, c_opc_op_imm32: w_result = {{32{w_alu32[31]}}, w_alu32};
            c_opc_lui:                  w_result = exe_ALU2;
            c_opc_jal, c_opc_jalr:      w_result = exe_PC + 64'd4;
            c_opc_system: begin
                case (w_f3[1:0])
                    2'b01:   w_result = exe_ALU1;
                    2'b10:   w_result = exe_CSRFD | exe_ALU1;
                    2'b11:   w_result = exe_CSRFD & ~exe_ALU1;
                    default: w_result = 64'd0;
                endcase
            end
            default:                    w_result = exe_ALU1 + exe_ALU2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_V          <= 1'b0;
            mem_PC         <= 64'd0;
            mem_IR         <= 32'd0;
            mem_ALU_RESULT <= 64'd0;
            mem_SR1        <= 64'd0;
            mem_SR2        <= 64'd0;
            mem_RFD        <= 64'd0;
            mem_CSRFD      <= 64'd0;
        end else if (!mem_stall) begin
            mem_V          <= exe_V;
            mem_PC         <= exe_PC;
            mem_IR         <= exe_IR;
            mem_ALU_RESULT <= w_result;
            mem_SR1        <= exe_ALU1;
            mem_SR2        <= exe_ALU2;
            mem_RFD        <= exe_RFD;
            mem_CSRFD      <= exe_CSRFD;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Scoreboard bench for execute_stage with directed ALU/CSR vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_execute_stage;

    logic        clk;
    logic        rst_n;
    logic        exe_V;
    logic        mem_stall;
    logic [31:0] exe_IR;
    logic [63:0] exe_PC, exe_ALU1, exe_ALU2, exe_RFD, exe_CSRFD;
    logic        mem_V;
    logic [63:0] mem_PC;
    logic [31:0] mem_IR;
    logic [63:0] mem_ALU_RESULT, mem_SR1, mem_SR2, mem_RFD, mem_CSRFD;

    typedef struct {
        logic        v;
        logic [31:0] ir;
        logic [63:0] pc, a, b, rfd, csr, res;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic loaded   = 1'b0;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .exe_V(exe_V), .mem_stall(mem_stall),
        .exe_IR(exe_IR), .exe_PC(exe_PC), .exe_ALU1(exe_ALU1), .exe_ALU2(exe_ALU2),
        .exe_RFD(exe_RFD), .exe_CSRFD(exe_CSRFD),
        .mem_V(mem_V), .mem_PC(mem_PC), .mem_IR(mem_IR),
        .mem_ALU_RESULT(mem_ALU_RESULT), .mem_SR1(mem_SR1), .mem_SR2(mem_SR2),
        .mem_RFD(mem_RFD), .mem_CSRFD(mem_CSRFD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Marks edges at which the output latches were expected to load.
    always @(posedge clk) loaded <= rst_n && !mem_stall;

    always @(negedge clk) begin
        if (loaded && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("result", mem_ALU_RESULT, e.res);
            chk("mem_V",  {63'd0, mem_V}, {63'd0, e.v});
            chk("mem_PC", mem_PC, e.pc);
            chk("mem_IR", {32'd0, mem_IR}, {32'd0, e.ir});
            chk("mem_SR1", mem_SR1, e.a);
            chk("mem_SR2", mem_SR2, e.b);
            chk("mem_RFD", mem_RFD, e.rfd);
            chk("mem_CSRFD", mem_CSRFD, e.csr);
        end
    end

    // Called just after a falling edge: drive, let the rising edge load it,
    // queue the expectation, and return at the next falling edge.
    task automatic issue(input logic v, input logic [31:0] ir, input logic [63:0] pc,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] rfd,
                         input logic [63:0] csr, input logic [63:0] res);
        exp_t e;
        exe_V = v; exe_IR = ir; exe_PC = pc; exe_ALU1 = a; exe_ALU2 = b;
        exe_RFD = rfd; exe_CSRFD = csr;
        e.v = v; e.ir = ir; e.pc = pc; e.a = a; e.b = b; e.rfd = rfd; e.csr = csr; e.res = res;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_V"},   {63'd0, mem_V}, 64'd0);
        chk({tag, "_PC"},  mem_PC, 64'd0);
        chk({tag, "_IR"},  {32'd0, mem_IR}, 64'd0);
        chk({tag, "_RES"}, mem_ALU_RESULT, 64'd0);
        chk({tag, "_SR1"}, mem_SR1, 64'd0);
        chk({tag, "_SR2"}, mem_SR2, 64'd0);
        chk({tag, "_RFD"}, mem_RFD, 64'd0);
        chk({tag, "_CSR"}, mem_CSRFD, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        rst_n = 1'b1; mem_stall = 1'b0; exe_V = 1'b0; exe_IR = 32'd0;
        exe_PC = 64'd0; exe_ALU1 = 64'd0; exe_ALU2 = 64'd0; exe_RFD = 64'd0; exe_CSRFD = 64'd0;
        #1 rst_n = 1'b0;
        #2 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(1, 32'h00007013, 64'h1000, 64'd0, 64'd0, 64'h11, 64'h22, 64'd0);            // ANDI
        issue(1, 32'h00000033, 64'h1004, 64'd5, 64'd5, 64'h0, 64'h0, 64'd10);             // ADD
        issue(1, 32'h40000033, 64'h1008, 64'd5, 64'd2, 64'h0, 64'h0, 64'd3);              // SUB
        issue(1, 32'h40000013, 64'h100C, 64'd5, 64'd2, 64'h0, 64'h0, 64'd7);              // ADDI, bit30 set
        issue(1, 32'hFFF06013, 64'h1010, 64'd5, ONES, 64'h0, 64'h0, ONES);                // ORI
        issue(1, 32'h00002033, 64'h1014, 64'd5, 64'd10, 64'h0, 64'h0, 64'd1);             // SLT
        issue(1, 32'h00002033, 64'h1018, ONES, 64'd1, 64'h0, 64'h0, 64'd1);               // SLT signed
        issue(1, 32'h00003033, 64'h101C, ONES, 64'd1, 64'h0, 64'h0, 64'd0);               // SLTU
        issue(1, 32'h40005033, 64'h1020, 64'h8000_0000_0000_0000, 64'd4, 0, 0, 64'hF800_0000_0000_0000); // SRA
        issue(1, 32'h00005033, 64'h1024, 64'h8000_0000_0000_0000, 64'd4, 0, 0, 64'h0800_0000_0000_0000); // SRL
        issue(1, 32'h03F01013, 64'h1028, 64'd1, 64'd63, 0, 0, 64'h8000_0000_0000_0000);   // SLLI 63
        issue(1, 32'h40004033, 64'h102C, 64'hF0, 64'hFF, 0, 0, 64'h0F);                   // XOR, alt ignored
        issue(1, 32'h0000003B, 64'h1030, 64'h7FFF_FFFF, 64'd1, 0, 0, 64'hFFFF_FFFF_8000_0000); // ADDW
        issue(1, 32'h4000503B, 64'h1034, 64'h8000_0000, 64'd4, 0, 0, 64'hFFFF_FFFF_F800_0000); // SRAW
        issue(1, 32'h0000203B, 64'h1038, 64'd5, 64'd5, 0, 0, 64'd0);                      // OP-32 f3=010
        issue(1, 32'h00000037, 64'h103C, 64'd0, 64'h1234_5000, 0, 0, 64'h1234_5000);      // LUI
        issue(1, 32'h0000006F, 64'h100, 64'd7, 64'd9, 0, 0, 64'h104);                     // JAL
        issue(1, 32'h00002073, 64'h1040, 64'h0F, 64'd0, 0, 64'hF0, 64'hFF);               // CSRRS
        issue(1, 32'h00003073, 64'h1044, 64'h0F, 64'd0, 0, 64'hFF, 64'hF0);               // CSRRC
        issue(1, 32'h00001073, 64'h1048, 64'h55, 64'd0, 0, 64'hFF, 64'h55);               // CSRRW
        issue(1, 32'h00000073, 64'h104C, 64'h55, 64'd3, 0, 64'hFF, 64'd0);                // ECALL
        issue(0, 32'h00000003, 64'h1050, 64'h200, 64'h8, 64'h9, 0, 64'h208);              // invalid LOAD
        issue(1, 32'h40000033, 64'd24, 64'd5, 64'd2, 64'hAB, 64'h0, 64'd3);               // pass-through

        // Stall: inputs change for three edges, outputs must keep the last load.
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exe_V = ~exe_V; exe_IR = 32'h00000033; exe_PC = 64'h9000 + 64'(i);
            exe_ALU1 = 64'(i) + 64'd100; exe_ALU2 = 64'd1; exe_RFD = 64'h77; exe_CSRFD = 64'h66;
            @(negedge clk);
            chk("stall_res", mem_ALU_RESULT, 64'd3);
            chk("stall_PC",  mem_PC, 64'd24);
            chk("stall_V",   {63'd0, mem_V}, 64'd1);
            chk("stall_RFD", mem_RFD, 64'hAB);
        end
        mem_stall = 1'b0;
        issue(1, 32'h00000033, 64'h2000, 64'd40, 64'd2, 64'h1, 64'h2, 64'd42);

        // Asynchronous reset mid-cycle, with a stall also pending.
        mem_stall = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        chk_zero("rst_hold");
        rst_n = 1'b1;
        mem_stall = 1'b0;
        issue(1, 32'h00000033, 64'h3000, 64'd1, 64'd1, 64'h5, 64'h6, 64'd2);
        @(negedge clk);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
